// File: rtl/hpdcache_pkg.sv
// Shared HPDcache types: transaction/source ID widths, physical tag, PMA, core request and response
// layouts, and the request-initiator FIFO entry.
package hpdcache_pkg;

    localparam int unsigned HPDCACHE_REQ_TRANS_ID_WIDTH = 4;
    localparam int unsigned HPDCACHE_REQ_SRC_ID_WIDTH   = 3;
    localparam int unsigned HPDCACHE_TAG_WIDTH          = 20;

    typedef logic [HPDCACHE_REQ_TRANS_ID_WIDTH-1:0] hpdcache_req_tid_t;
    typedef logic [HPDCACHE_REQ_SRC_ID_WIDTH-1:0]   hpdcache_req_sid_t;
    typedef logic [HPDCACHE_TAG_WIDTH-1:0]          hpdcache_tag_t;

    typedef struct packed {
        logic uncacheable;
        logic io;
    } hpdcache_pma_t;

    typedef struct packed {
        logic [11:0]       addr_offset;
        logic [3:0]        op;
        logic              need_rsp;
        hpdcache_req_sid_t sid;
        hpdcache_req_tid_t tid;
    } hpdcache_req_t;

    typedef struct packed {
        logic [31:0]       rdata;
        hpdcache_req_sid_t sid;
        hpdcache_req_tid_t tid;
        logic              error;
    } hpdcache_rsp_t;

    typedef struct packed {
        hpdcache_req_t req;
        logic          abort;
        hpdcache_tag_t tag;
        hpdcache_pma_t pma;
    } hpdcache_req_initiator_entry_t;

endpackage

// File: rtl/hpdcache_fifo_reg.sv
// Register-based FIFO, power-of-2 depth. Push and pop may coincide in any state, including full.
module hpdcache_fifo_reg #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DATA_W     = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              w_i,
    output logic              wok_o,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              r_i,
    output logic              rok_o,
    output logic [DATA_W-1:0] rdata_o
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr_q, rptr_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              push, pop;

    assign rok_o   = (cnt_q != '0);
    assign wok_o   = (cnt_q != CNT_W'(FIFO_DEPTH));
    assign pop     = r_i & rok_o;
    assign push    = w_i & (wok_o | pop);
    assign rdata_o = mem_q[rptr_q];

    always_comb begin
        // NOTE: default assigned first so no path leaves cnt_d unassigned (no latch).
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // NOTE: storage is not reset; entries are only read after being written, and the count gates that.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= wdata_i;
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PTR_W'(1);
            if (pop)  rptr_q <= rptr_q + PTR_W'(1);
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hpdcache_tid_alloc.sv
// Transaction-ID allocator: in-use bitmap, lowest-index free TID, alloc/free ports, registered count.
module hpdcache_tid_alloc #(
    parameter int unsigned N_TIDS = 8,
    parameter int unsigned TID_W  = 4,
    parameter int unsigned CNT_W  = $clog2(N_TIDS + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             alloc_i,
    input  logic [TID_W-1:0] alloc_tid_i,
    input  logic             free_i,
    input  logic [TID_W-1:0] free_tid_i,
    output logic             free_hit_o,
    output logic             avail_o,
    output logic [TID_W-1:0] lowest_tid_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int unsigned IDX_W = (N_TIDS > 1) ? $clog2(N_TIDS) : 1;

    logic [N_TIDS-1:0] used_q, used_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              free_in_range;

    assign free_in_range = (32'(free_tid_i) < N_TIDS);
    assign free_hit_o    = free_in_range & used_q[free_tid_i[IDX_W-1:0]];
    assign avail_o       = ~&used_q;
    assign count_o       = count_q;

    always_comb begin
        lowest_tid_o = '0;
        for (int i = N_TIDS - 1; i >= 0; i--) begin
            if (!used_q[i]) lowest_tid_o = TID_W'(i);
        end
    end

    // Allocation looks only at used_q, so a TID freed this cycle is not reused before the next one.
    always_comb begin
        used_d = used_q;
        if (free_i && free_hit_o) used_d[free_tid_i[IDX_W-1:0]] = 1'b0;
        if (alloc_i)              used_d[alloc_tid_i[IDX_W-1:0]] = 1'b1;
        count_d = '0;
        for (int i = 0; i < N_TIDS; i++) count_d = count_d + CNT_W'(used_d[i]);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            used_q  <= '0;
            count_q <= '0;
        end else begin
            used_q  <= used_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/hpdcache_req_initiator.sv
// Requester-side initiator for one HPDcache port: request FIFO, TID allocation, two-phase request.
// Defining HPDCACHE_REQ_INITIATOR_PERF_EN adds perf_issue_o and perf_stall_tid_o.
module hpdcache_req_initiator
    import hpdcache_pkg::*;
#(
    parameter int unsigned  SID       = 0,
    parameter int unsigned  FifoDepth = 4,
    parameter int unsigned  nTids     = 8,
    localparam int unsigned CNTW      = $clog2(nTids + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  hpdcache_req_t   in_req_i,
    input  logic            in_abort_i,
    input  hpdcache_tag_t   in_tag_i,
    input  hpdcache_pma_t   in_pma_i,
    output logic            req_valid_o,
    input  logic            req_ready_i,
    output hpdcache_req_t   req_o,
    output logic            req_abort_o,
    output hpdcache_tag_t   req_tag_o,
    output hpdcache_pma_t   req_pma_o,
    input  logic            rsp_valid_i,
    output logic            rsp_ready_o,
    input  hpdcache_rsp_t   rsp_i,
    output logic            out_rsp_valid_o,
    input  logic            out_rsp_ready_i,
    output hpdcache_rsp_t   out_rsp_o,
    output logic [CNTW-1:0] outstanding_o,
    output logic            err_o
`ifdef HPDCACHE_REQ_INITIATOR_PERF_EN
    ,
    output logic            perf_issue_o,
    output logic            perf_stall_tid_o
`endif
);
    localparam int unsigned ENTRY_W = $bits(hpdcache_req_initiator_entry_t);

    hpdcache_req_initiator_entry_t in_entry, head;
    logic [ENTRY_W-1:0]            head_raw;
    logic                          fifo_wok, fifo_rok, req_hs, rsp_hs;
    logic                          tid_avail, tid_in_use;
    hpdcache_req_tid_t             lowest_tid, tid_sel;
    logic                          hold_q, hold_d;
    hpdcache_req_tid_t             held_tid_q, held_tid_d;
    logic                          abort_q, abort_d, err_q, err_d;
    hpdcache_tag_t                 tag_q, tag_d;
    hpdcache_pma_t                 pma_q, pma_d;

    assign in_entry = '{req: in_req_i, abort: in_abort_i, tag: in_tag_i, pma: in_pma_i};
    assign head     = head_raw;

    hpdcache_fifo_reg #(
        .FIFO_DEPTH(FifoDepth),
        .DATA_W    (ENTRY_W)
    ) i_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .w_i    (in_valid_i & fifo_wok),
        .wok_o  (fifo_wok),
        .wdata_i(in_entry),
        .r_i    (req_hs),
        .rok_o  (fifo_rok),
        .rdata_o(head_raw)
    );

    hpdcache_tid_alloc #(
        .N_TIDS(nTids),
        .TID_W (HPDCACHE_REQ_TRANS_ID_WIDTH),
        .CNT_W (CNTW)
    ) i_tid_alloc (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .alloc_i     (req_hs & head.req.need_rsp),
        .alloc_tid_i (tid_sel),
        .free_i      (rsp_hs),
        .free_tid_i  (rsp_i.tid),
        .free_hit_o  (tid_in_use),
        .avail_o     (tid_avail),
        .lowest_tid_o(lowest_tid),
        .count_o     (outstanding_o)
    );

    // A stalled request keeps its TID even if a lower one is freed meanwhile, so req_o stays stable.
    assign tid_sel     = hold_q ? held_tid_q : lowest_tid;
    assign in_ready_o  = fifo_wok;
    assign req_valid_o = fifo_rok & (~head.req.need_rsp | tid_avail);
    assign req_hs      = req_valid_o & req_ready_i;
    assign rsp_hs      = rsp_valid_i & out_rsp_ready_i;

    always_comb begin
        req_o     = head.req;
        req_o.sid = hpdcache_req_sid_t'(SID);
        req_o.tid = head.req.need_rsp ? tid_sel : '0;
    end

    assign rsp_ready_o     = out_rsp_ready_i;
    assign out_rsp_valid_o = rsp_valid_i;
    assign out_rsp_o       = rsp_i;
    assign req_abort_o     = abort_q;
    assign req_tag_o       = tag_q;
    assign req_pma_o       = pma_q;
    assign err_o           = err_q;

    always_comb begin
        hold_d     = req_valid_o & ~req_ready_i;
        held_tid_d = tid_sel;
        abort_d    = req_hs & head.abort;
        tag_d      = req_hs ? head.tag : '0;
        pma_d      = req_hs ? head.pma : '0;
        err_d      = err_q | (rsp_hs & ~tid_in_use);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_q     <= 1'b0;
            held_tid_q <= '0;
            abort_q    <= 1'b0;
            tag_q      <= '0;
            pma_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            held_tid_q <= held_tid_d;
            abort_q    <= abort_d;
            tag_q      <= tag_d;
            pma_q      <= pma_d;
            err_q      <= err_d;
        end
    end

`ifdef HPDCACHE_REQ_INITIATOR_PERF_EN
    assign perf_issue_o     = req_hs;
    assign perf_stall_tid_o = fifo_rok & head.req.need_rsp & ~tid_avail;
`endif

endmodule

// File: tb/tb_hpdcache_req_initiator.sv
// Bench for hpdcache_req_initiator: queue/bitmap reference model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_hpdcache_req_initiator;
    import hpdcache_pkg::*;

    localparam int unsigned SID   = 3;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned NTIDS = 8;
    localparam int unsigned CNTW  = $clog2(NTIDS + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    hpdcache_req_t in_req_i = '0;
    logic          in_abort_i = 1'b0;
    hpdcache_tag_t in_tag_i = '0;
    hpdcache_pma_t in_pma_i = '0;
    logic          req_valid_o;
    logic          req_ready_i = 1'b0;
    hpdcache_req_t req_o;
    logic          req_abort_o;
    hpdcache_tag_t req_tag_o;
    hpdcache_pma_t req_pma_o;
    logic          rsp_valid_i = 1'b0;
    logic          rsp_ready_o;
    hpdcache_rsp_t rsp_i = '0;
    logic          out_rsp_valid_o;
    logic          out_rsp_ready_i = 1'b1;
    hpdcache_rsp_t out_rsp_o;
    logic [CNTW-1:0] outstanding_o;
    logic          err_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hpdcache_req_initiator #(
        .SID      (SID),
        .FifoDepth(DEPTH),
        .nTids    (NTIDS)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .in_req_i       (in_req_i),
        .in_abort_i     (in_abort_i),
        .in_tag_i       (in_tag_i),
        .in_pma_i       (in_pma_i),
        .req_valid_o    (req_valid_o),
        .req_ready_i    (req_ready_i),
        .req_o          (req_o),
        .req_abort_o    (req_abort_o),
        .req_tag_o      (req_tag_o),
        .req_pma_o      (req_pma_o),
        .rsp_valid_i    (rsp_valid_i),
        .rsp_ready_o    (rsp_ready_o),
        .rsp_i          (rsp_i),
        .out_rsp_valid_o(out_rsp_valid_o),
        .out_rsp_ready_i(out_rsp_ready_i),
        .out_rsp_o      (out_rsp_o),
        .outstanding_o  (outstanding_o),
        .err_o          (err_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, TIDs as an in-use array, second phase as a one-deep pipe.
    hpdcache_req_initiator_entry_t m_fifo[$];
    bit                            m_used[NTIDS];
    bit                            m_err = 1'b0;
    bit                            m_ph2_v = 1'b0;
    hpdcache_req_initiator_entry_t m_ph2 = '0;
    bit                            m_stall = 1'b0;
    hpdcache_req_t                 m_prev_req = '0;
    bit                            e_valid = 1'b0;
    bit                            e_in_ready = 1'b1;
    hpdcache_req_t                 e_req = '0;

    function automatic int lowest_free();
        for (int i = 0; i < NTIDS; i++) if (!m_used[i]) return i;
        return -1;
    endfunction

    function automatic int n_used();
        int n = 0;
        for (int i = 0; i < NTIDS; i++) n += int'(m_used[i]);
        return n;
    endfunction

    always begin
        hpdcache_req_initiator_entry_t h;
        int lf;
        @(negedge clk);
        e_in_ready = (m_fifo.size() < DEPTH);
        e_valid    = 1'b0;
        e_req      = '0;
        lf         = lowest_free();
        if (m_fifo.size() > 0) begin
            h         = m_fifo[0];
            e_valid   = !h.req.need_rsp || (lf >= 0);
            e_req     = h.req;
            e_req.sid = hpdcache_req_sid_t'(SID);
            e_req.tid = h.req.need_rsp ? hpdcache_req_tid_t'(lf) : '0;
            if (m_stall) e_req = m_prev_req;
        end
        check("in_ready_o", 64'(in_ready_o), 64'(e_in_ready));
        check("req_valid_o", 64'(req_valid_o), 64'(e_valid));
        if (e_valid) check("req_o", 64'(req_o), 64'(e_req));
        check("req_abort_o", 64'(req_abort_o), m_ph2_v ? 64'(m_ph2.abort) : 64'd0);
        check("req_tag_o", 64'(req_tag_o), m_ph2_v ? 64'(m_ph2.tag) : 64'd0);
        check("req_pma_o", 64'(req_pma_o), m_ph2_v ? 64'(m_ph2.pma) : 64'd0);
        check("outstanding_o", 64'(outstanding_o), 64'(n_used()));
        check("err_o", 64'(err_o), 64'(m_err));
        check("rsp_ready_o", 64'(rsp_ready_o), 64'(out_rsp_ready_i));
        check("out_rsp_valid_o", 64'(out_rsp_valid_o), 64'(rsp_valid_i));
        check("out_rsp_o", 64'(out_rsp_o), 64'(rsp_i));
    end

    always begin
        hpdcache_req_initiator_entry_t h;
        int t;
        @(posedge clk or posedge rst);
        if (rst) begin
            m_fifo.delete();
            for (int i = 0; i < NTIDS; i++) m_used[i] = 1'b0;
            m_err   = 1'b0;
            m_ph2_v = 1'b0;
            m_stall = 1'b0;
        end else begin
            if (rsp_valid_i && out_rsp_ready_i) begin
                t = int'(rsp_i.tid);
                if (t < NTIDS && m_used[t]) m_used[t] = 1'b0;
                else m_err = 1'b1;
            end
            m_ph2_v = e_valid && req_ready_i;
            if (m_ph2_v) begin
                h     = m_fifo.pop_front();
                m_ph2 = h;
                if (h.req.need_rsp) m_used[int'(e_req.tid)] = 1'b1;
            end
            if (in_valid_i && e_in_ready)
                m_fifo.push_back('{req: in_req_i, abort: in_abort_i, tag: in_tag_i, pma: in_pma_i});
            m_stall    = e_valid && !req_ready_i;
            m_prev_req = e_req;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic need_rsp, input logic [11:0] addr, input logic abort,
                        input hpdcache_tag_t tag, input hpdcache_pma_t pma);
        logic done;
        done       = 1'b0;
        in_valid_i = 1'b1;
        in_req_i   = '{addr_offset: addr, op: 4'h3, need_rsp: need_rsp, sid: '1, tid: '1};
        in_abort_i = abort;
        in_tag_i   = tag;
        in_pma_i   = pma;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = in_ready_o;
            step();
        end
        in_valid_i = 1'b0;
        check("push_accepted", 64'(done), 64'd1);
    endtask

    task automatic respond(input int tid);
        rsp_valid_i = 1'b1;
        rsp_i       = '{rdata: 32'hC0DE_0000 + 32'(tid), sid: hpdcache_req_sid_t'(SID),
                        tid: hpdcache_req_tid_t'(tid), error: 1'b0};
        step();
        rsp_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        check("rst_in_ready", 64'(in_ready_o), 64'd1);
        check("rst_req_valid", 64'(req_valid_o), 64'd0);
        check("rst_outstanding", 64'(outstanding_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        rst = 1'b0;
        step();

        // Single request: issue on the cycle after the push, second phase one cycle later.
        req_ready_i = 1'b1;
        push(1'b1, 12'h010, 1'b1, 20'hABCDE, '{uncacheable: 1'b1, io: 1'b0});
        check("t1_valid", 64'(req_valid_o), 64'd1);
        check("t1_tid", 64'(req_o.tid), 64'd0);
        check("t1_sid", 64'(req_o.sid), 64'd3);
        step();
        check("t1_abort", 64'(req_abort_o), 64'd1);
        check("t1_tag", 64'(req_tag_o), 64'hABCDE);
        check("t1_pma", 64'(req_pma_o), 64'h2);
        check("t1_outstanding", 64'(outstanding_o), 64'd1);
        step();
        check("t1_tag_cleared", 64'(req_tag_o), 64'd0);
        respond(0);
        check("t1_freed", 64'(outstanding_o), 64'd0);

        // Nine need_rsp requests with no responses: eight issue, the ninth waits for a free TID.
        for (int k = 0; k < 9; k++)
            push(1'b1, 12'(k), 1'b0, hpdcache_tag_t'(k), '0);
        step();
        step();
        check("t2_outstanding_full", 64'(outstanding_o), 64'd8);
        check("t2_ninth_held", 64'(req_valid_o), 64'd0);
        respond(3);
        check("t2_ninth_valid", 64'(req_valid_o), 64'd1);
        check("t2_ninth_tid", 64'(req_o.tid), 64'd3);
        check("t2_outstanding_7", 64'(outstanding_o), 64'd7);
        step();
        check("t2_ninth_tag", 64'(req_tag_o), 64'd8);
        check("t2_outstanding_8", 64'(outstanding_o), 64'd8);

        // need_rsp=0 goes out with tid 0 even though every TID is busy.
        push(1'b0, 12'h044, 1'b0, 20'h00044, '0);
        check("t4_valid", 64'(req_valid_o), 64'd1);
        check("t4_tid", 64'(req_o.tid), 64'd0);
        step();
        check("t4_tag", 64'(req_tag_o), 64'h44);
        check("t4_outstanding", 64'(outstanding_o), 64'd8);

        for (int t = 0; t < NTIDS; t++) respond(t);
        check("t3_all_free", 64'(outstanding_o), 64'd0);

        // Full FIFO under backpressure, then four back-to-back issues.
        req_ready_i = 1'b0;
        for (int k = 0; k < 4; k++)
            push(1'b1, 12'h100 + 12'(k), k[0], hpdcache_tag_t'(32'h100 + k),
                 '{uncacheable: k[1], io: k[0]});
        for (int c = 0; c < 5; c++) begin
            check("t3_full", 64'(in_ready_o), 64'd0);
            check("t3_hold_valid", 64'(req_valid_o), 64'd1);
            check("t3_hold_tid", 64'(req_o.tid), 64'd0);
            check("t3_hold_addr", 64'(req_o.addr_offset), 64'h100);
            step();
        end
        req_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("t3_b2b_valid", 64'(req_valid_o), 64'd1);
            check("t3_b2b_tid", 64'(req_o.tid), 64'(k));
            step();
            check("t3_b2b_tag", 64'(req_tag_o), 64'(32'h100 + k));
            check("t3_b2b_abort", 64'(req_abort_o), 64'(k[0]));
        end
        step();
        check("t3_drained", 64'(req_valid_o), 64'd0);
        check("t3_outstanding", 64'(outstanding_o), 64'd4);

        // Response for a free TID sets the sticky error; a refused response frees nothing.
        respond(5);
        check("t5_err", 64'(err_o), 64'd1);
        check("t5_outstanding", 64'(outstanding_o), 64'd4);
        out_rsp_ready_i = 1'b0;
        rsp_valid_i     = 1'b1;
        rsp_i.tid       = '0;
        #1;
        check("t5_rsp_ready", 64'(rsp_ready_o), 64'd0);
        step();
        rsp_valid_i     = 1'b0;
        out_rsp_ready_i = 1'b1;
        check("t5_not_freed", 64'(outstanding_o), 64'd4);
        repeat (3) step();
        check("t5_err_sticky", 64'(err_o), 64'd1);

        // Reset while a second phase is on the outputs and the FIFO still holds a request.
        req_ready_i = 1'b0;
        push(1'b1, 12'h200, 1'b1, 20'h00200, '{uncacheable: 1'b0, io: 1'b1});
        push(1'b1, 12'h201, 1'b0, 20'h00201, '0);
        req_ready_i = 1'b1;
        check("t6_tid", 64'(req_o.tid), 64'd4);
        step();
        check("t6_tag", 64'(req_tag_o), 64'h200);
        rst = 1'b1;
        #1;
        check("t6_rst_tag", 64'(req_tag_o), 64'd0);
        check("t6_rst_abort", 64'(req_abort_o), 64'd0);
        check("t6_rst_pma", 64'(req_pma_o), 64'd0);
        check("t6_rst_outstanding", 64'(outstanding_o), 64'd0);
        check("t6_rst_valid", 64'(req_valid_o), 64'd0);
        check("t6_rst_err", 64'(err_o), 64'd0);
        step();
        step();
        rst = 1'b0;
        step();
        check("t6_empty", 64'(req_valid_o), 64'd0);
        check("t6_in_ready", 64'(in_ready_o), 64'd1);
        push(1'b1, 12'h300, 1'b0, 20'h00300, '0);
        check("t6_after_tid", 64'(req_o.tid), 64'd0);
        step();
        check("t6_after_outstanding", 64'(outstanding_o), 64'd1);
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
